// File: rtl/data_memory_responder.sv
// Multi-cycle doubleword data memory behind valid/ready request and response channels.
// One request in flight; bad addresses are flagged and never touch the array.
module data_memory_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} stateT;

  stateT             state;
  stateT             nextState;
  logic [CNT_W-1:0]  latCnt;
  logic              capWrite;
  logic [63:0]       capAddr;
  logic [63:0]       capWdata;
  logic [63:0]       mem [DEPTH_WORDS];

  logic              accept_c;
  logic              commit_c;
  logic              addrErr_c;
  logic [IDX_W-1:0]  wordIdx_c;

  // Range check spans all upper address bits, so high addresses never wrap.
  assign addrErr_c = (capAddr[2:0] != 3'd0) || (capAddr[63:3] >= 61'(DEPTH_WORDS));
  assign wordIdx_c = capAddr[IDX_W+2:3];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    accept_c  = 1'b0;
    commit_c  = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        accept_c  = 1'b1;
        nextState = BUSY;
      end
      BUSY: if (latCnt == '0) begin
        commit_c  = 1'b1;
        nextState = RESP;
      end
      RESP: if (resp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the upcoming state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
    end else begin
      req_ready  <= (nextState == IDLE);
      resp_valid <= (nextState == RESP);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      latCnt     <= '0;
      capWrite   <= 1'b0;
      capAddr    <= '0;
      capWdata   <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      if (accept_c) begin
        capWrite <= req_write;
        capAddr  <= req_addr;
        capWdata <= req_wdata;
        latCnt   <= CNT_W'(LATENCY - 1);
      end else if (state == BUSY && latCnt != '0) begin
        latCnt <= latCnt - CNT_W'(1);
      end
      if (commit_c) begin
        resp_error <= addrErr_c;
        resp_rdata <= (!addrErr_c && !capWrite) ? mem[wordIdx_c] : 64'd0;
      end
    end
  end

  // Array is cleared on reset so an uncommitted store leaves no trace.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (commit_c && capWrite && !addrErr_c) begin
      mem[wordIdx_c] <= capWdata;
    end
  end

endmodule
